// File: rtl/bht_predictor.sv
// Branch history table of 2-bit saturating counters: combinational direction
// prediction in IF, training and direction-mispredict reporting from EX.
module bht_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  input  logic        BTB_find,
  input  logic        bubbleE,
  input  logic [31:0] PC_EX,
  input  logic        is_br_EX,
  input  logic        br_EX,
  input  logic        pred_taken_EX,
  output logic        pred_taken,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            ctr_table [ENTRIES];
  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic                  upd;
  logic [1:0]            cur_ctr;
  logic [1:0]            next_ctr;
  logic [31:0]           br_cnt_q;
  logic [31:0]           miss_cnt_q;
  logic                  unused_pc_bits;

  // Direct-mapped, untagged: word-aligned PC bits select the entry.
  assign rd_idx = PC_IF[INDEX_BITS+1:2];
  assign wr_idx = PC_EX[INDEX_BITS+1:2];

  assign unused_pc_bits = ^{PC_IF[31:INDEX_BITS+2], PC_IF[1:0],
                            PC_EX[31:INDEX_BITS+2], PC_EX[1:0]};

  // Read returns the stored value; a same-cycle write to this entry shows next cycle.
  assign pred_taken = BTB_find & ctr_table[rd_idx][1];

  // Independent of bubbleE so flush control sees it while EX is held.
  assign mispredict = is_br_EX & (br_EX ^ pred_taken_EX);

  assign upd     = is_br_EX & ~bubbleE;
  assign cur_ctr = ctr_table[wr_idx];

  always_comb begin
    // NOTE: default first so every path assigns next_ctr and no latch is inferred.
    next_ctr = cur_ctr;
    if (br_EX) begin
      if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'b01;
    end
  end

  // NOTE: the table is a flop array with async reset on every entry, so it
  // cannot map onto block RAM; that is intentional, reset must initialise it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= INIT_STATE;
    end else if (upd) begin
      ctr_table[wr_idx] <= next_ctr;
    end
  end

  // Statistics wrap silently at 2**32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (upd) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign br_count   = br_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- 2-bit saturating-counter Branch History Table in the IF stage, beside the BTB.
- Gives the taken/not-taken direction for conditional branches. The BTB supplies the target on a hit; this block decides whether the NPC generator uses that target.
- Trains from the resolved branch outcome in EX and reports direction mispredicts for flush control.
- Holds 32-bit branch and mispredict counters for lab statistics.

Parameters:
- INDEX_BITS, 6, log2 of table entries; table has 2**INDEX_BITS entries.
- INIT_STATE, 2'b01, counter value loaded into every entry at reset (weakly not-taken).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- PC_IF  input  32  fetch PC.
- BTB_find  input  1  BTB hit for PC_IF.
- bubbleE  input  1  EX stage held; suppresses training and statistics.
- PC_EX  input  32  PC of the instruction in EX (already corrected to its own address).
- is_br_EX  input  1  EX instruction is a conditional branch.
- br_EX  input  1  resolved outcome; 1 = taken.
- pred_taken_EX  input  1  pred_taken value carried down the pipe with this instruction.
- pred_taken  output  1  direction prediction for PC_IF.
- mispredict  output  1  EX direction mispredict, combinational.
- br_count  output  32  conditional branches retired from EX.
- miss_count  output  32  direction mispredicts.

Behaviour:
- Index: idx(x) = x[INDEX_BITS+1:2]. Bits [1:0] are ignored. No tag: aliasing is accepted.
- Read: combinational, no latency.
  - pred_taken = BTB_find & table[idx(PC_IF)][1].
  - On a BTB miss, pred_taken = 0 regardless of counter state.
- Update condition: upd = is_br_EX & ~bubbleE. Applied on the rising edge of clk.
  - br_EX = 1: counter increments, saturating at 2'b11.
  - br_EX = 0: counter decrements, saturating at 2'b00.
  - Transitions: 00<->01<->10<->11. Taken at 11 stays 11; not-taken at 00 stays 00.
  - Non-branch instructions (jal, jalr, ALU, etc.) never modify the table.
- Same-cycle read and write to the same index: the read returns the pre-update value (no write-to-read bypass). The new value is visible from the next cycle.
- mispredict = is_br_EX & (br_EX ^ pred_taken_EX).
  - Combinational and independent of bubbleE, so flush logic sees it while EX is held.
- Statistics, both on the rising edge when upd = 1:
  - br_count increments by 1.
  - miss_count increments by 1 when mispredict is also 1.
  - Both counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0 silently.
- bubbleE = 1 with is_br_EX = 1 held for N cycles: table and counters change exactly once, on the cycle bubbleE falls.
- Reset (rst = 0, asynchronous, any time including mid-update):
  - Every table entry is set to INIT_STATE.
  - br_count = 0 and miss_count = 0.
  - pred_taken and mispredict follow their combinational inputs; with INIT_STATE = 01, pred_taken = 0.
  - An update coincident with reset assertion is discarded.
- Release: the first update is taken on the first rising edge with rst = 1.
- Storage: flop array, 2 × 2**INDEX_BITS bits. It must be asynchronously resettable, so no BRAM inference.

Test Plan:
- Reset: assert rst = 0 for 3 cycles, release, then sweep PC_IF 0x00..0xFC with BTB_find = 1 → pred_taken = 0 at every index; br_count = miss_count = 0.
- Saturating up:
  - PC_EX = 0x40, is_br_EX = 1, br_EX = 1, pred_taken_EX = 0, for 4 cycles.
  - Counter goes 01→10→11→11.
  - With PC_IF = 0x40 and BTB_find = 1, pred_taken = 1 from cycle 2 on.
  - br_count = 4, miss_count = 4.
- Saturating down: then 4 not-taken updates at 0x40 with pred_taken_EX = 1 → counter 11→10→01→00→00; pred_taken = 0 after the 2nd update; miss_count = 8.
- Aliasing and gating:
  - Train 0x1040 taken ×2 → PC_IF = 0x0040 predicts taken (same index).
  - With BTB_find = 0 → pred_taken = 0.
  - PC_IF = 0x0044 → unaffected.
- Stall:
  - bubbleE = 1 for 5 cycles with a taken branch at 0x80 → no table or counter change.
  - mispredict = 1 throughout while pred_taken_EX = 0.
  - One update on bubbleE release → br_count +1.
- Wrap and async reset:
  - Force br_count to 0xFFFFFFFF, apply one update → 0x00000000.
  - Assert rst mid-cycle concurrent with an update → all entries 01, counters 0, update lost.
